// File: rtl/seg7_hex_decoder.sv
// Seven-segment snooper: debounces NDIG active-low patterns and recovers the hex nibble per digit.
// Optional saturating error counter enabled by SEG7_HEX_DECODER_ERR_CNT_EN.
module seg7_hex_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7*NDIG-1:0]   seg_n,
    input  logic                err_clr,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     digit_valid,
    output logic                update,
    output logic [NDIG-1:0]     err_sticky,
    output logic [7:0]          err_count
);

    localparam int              CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST    = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]      BLANK_N = 7'h7F;

    typedef enum logic {IDLE, COUNTING} state_t;

    state_t          state      [NDIG];
    state_t          state_next [NDIG];
    logic [6:0]      held       [NDIG];
    logic [6:0]      held_next  [NDIG];
    logic [CW-1:0]   count      [NDIG];
    logic [CW-1:0]   count_next [NDIG];

    logic [NDIG-1:0]   commit;
    logic [NDIG-1:0]   err_set;
    logic [4*NDIG-1:0] value_next;
    logic [NDIG-1:0]   valid_next;
    logic              changed;

    // Returns {recognized, code} for an active-high g..a pattern.
    function automatic logic [4:0] glyph_lookup(input logic [6:0] pat);
        case (pat)
            7'b0111111: return 5'h10;
            7'b0000110: return 5'h11;
            7'b1011011: return 5'h12;
            7'b1001111: return 5'h13;
            7'b1100110: return 5'h14;
            7'b1101101: return 5'h15;
            7'b1111101: return 5'h16;
            7'b0000111: return 5'h17;
            7'b1111111: return 5'h18;
            7'b1101111: return 5'h19;
            7'b1110111: return 5'h1A;
            7'b1111100: return 5'h1B;
            7'b0111001: return 5'h1C;
            7'b1011110: return 5'h1D;
            7'b1111001: return 5'h1E;
            7'b1110001: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        for (int d = 0; d < NDIG; d++) begin
            if (reset) begin
                state[d] <= IDLE;
                held[d]  <= BLANK_N;
                count[d] <= '0;
            end else begin
                state[d] <= state_next[d];
                held[d]  <= held_next[d];
                count[d] <= count_next[d];
            end
        end
    end

    // Any change of sample restarts the episode from the new pattern.
    always_comb begin
        for (int d = 0; d < NDIG; d++) begin
            state_next[d] = state[d];
            held_next[d]  = held[d];
            count_next[d] = count[d];
            if (seg_n[7*d +: 7] != held[d]) begin
                held_next[d] = seg_n[7*d +: 7];
                if (STABLE_CYCLES == 1) begin
                    state_next[d] = IDLE;
                    count_next[d] = '0;
                end else begin
                    state_next[d] = COUNTING;
                    count_next[d] = CW'(1);
                end
            end else if (state[d] == COUNTING) begin
                if (count[d] == LAST) begin
                    state_next[d] = IDLE;
                    count_next[d] = '0;
                end else begin
                    count_next[d] = count[d] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        commit     = '0;
        err_set    = '0;
        value_next = value;
        valid_next = digit_valid;
        for (int d = 0; d < NDIG; d++) begin
            if (seg_n[7*d +: 7] != held[d])
                commit[d] = (STABLE_CYCLES == 1);
            else
                commit[d] = (state[d] == COUNTING) && (count[d] == LAST);

            if (commit[d]) begin
                if (glyph_lookup(~seg_n[7*d +: 7]) >= 5'h10) begin
                    value_next[4*d +: 4] = glyph_lookup(~seg_n[7*d +: 7]) & 5'h0F;
                    valid_next[d]        = 1'b1;
                end else if (seg_n[7*d +: 7] == BLANK_N) begin
                    value_next[4*d +: 4] = 4'h0;
                    valid_next[d]        = 1'b0;
                end else begin
                    valid_next[d] = 1'b0;
                    err_set[d]    = 1'b1;
                end
            end
        end
        changed = (value_next != value) || (valid_next != digit_valid);
    end

    // A fresh error on the same edge as err_clr keeps its sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            value       <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            err_sticky  <= '0;
        end else begin
            value       <= value_next;
            digit_valid <= valid_next;
            update      <= changed;
            err_sticky  <= (err_sticky & ~{NDIG{err_clr}}) | err_set;
        end
    end

`ifdef SEG7_HEX_DECODER_ERR_CNT_EN
    logic [3:0] err_new;
    logic [8:0] err_sum;

    always_comb begin
        err_new = '0;
        for (int d = 0; d < NDIG; d++)
            err_new = err_new + 4'(err_set[d]);
        err_sum = {1'b0, (err_clr ? 8'h00 : err_count)} + 9'(err_new);
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_count <= 8'h00;
        else
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_hex_decoder.sv
// Directed-vector bench for seg7_hex_decoder (NDIG=4, STABLE_CYCLES=4).
// Covers err_count saturation when SEG7_HEX_DECODER_ERR_CNT_EN is defined.
module tb_seg7_hex_decoder;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] G2    = ~7'b1011011;
    localparam logic [6:0] GA    = ~7'b1110111;
    localparam logic [6:0] GF    = ~7'b1110001;
    localparam logic [6:0] G8    = ~7'b1111111;
    localparam logic [6:0] BAD1  = ~7'b1010101;
    localparam logic [6:0] BAD2  = ~7'b1010100;

    logic        clk = 1'b0;
    logic        reset;
    logic [27:0] seg_n;
    logic        err_clr;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        update;
    logic [3:0]  err_sticky;
    logic [7:0]  err_count;

    logic [6:0]  dig [4];
    int          vectors    = 0;
    int          miscompares = 0;
    int          upd_pulses = 0;

    seg7_hex_decoder #(.NDIG(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .err_clr     (err_clr),
        .value       (value),
        .digit_valid (digit_valid),
        .update      (update),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Drives the current digit patterns for n rising edges, sampling outputs 1ns after each edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            seg_n = {dig[3], dig[2], dig[1], dig[0]};
            @(posedge clk);
            #1;
            if (update) upd_pulses++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset   = 1'b1;
        err_clr = 1'b0;
        for (int i = 0; i < 4; i++) dig[i] = BLANK;
        applyStimulus(2);
        checkOutput("reset_value", 32'(value), 32'h0);
        checkOutput("reset_valid", 32'(digit_valid), 32'h0);
        checkOutput("reset_update", 32'(update), 32'h0);
        checkOutput("reset_err", 32'(err_sticky), 32'h0);
        checkOutput("reset_errcnt", 32'(err_count), 32'h0);
        reset = 1'b0;

        // Digit0 shows "2": commits on the fourth sample.
        upd_pulses = 0;
        dig[0] = G2;
        applyStimulus(3);
        checkOutput("d0_early_valid", 32'(digit_valid), 32'h0);
        applyStimulus(1);
        checkOutput("d0_value", 32'(value), 32'h0002);
        checkOutput("d0_valid", 32'(digit_valid), 32'h1);
        checkOutput("d0_update", 32'(update), 32'h1);
        applyStimulus(2);
        checkOutput("d0_pulses", 32'(upd_pulses), 32'h1);

        // Digit1 toggles A/F every two cycles, never stable long enough.
        upd_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            dig[1] = (i % 2 == 0) ? GA : GF;
            applyStimulus(2);
        end
        checkOutput("toggle_pulses", 32'(upd_pulses), 32'h0);
        checkOutput("toggle_valid", 32'(digit_valid), 32'h1);
        applyStimulus(4);
        checkOutput("d1_value", 32'(value), 32'h00F2);
        checkOutput("d1_valid", 32'(digit_valid), 32'h3);
        checkOutput("d1_pulses", 32'(upd_pulses), 32'h1);

        // Unrecognized pattern on digit2, then a second error coinciding with err_clr.
        upd_pulses = 0;
        dig[2] = BAD1;
        applyStimulus(4);
        checkOutput("bad_err", 32'(err_sticky), 32'h4);
        checkOutput("bad_valid", 32'(digit_valid), 32'h3);
        checkOutput("bad_value", 32'(value), 32'h00F2);
        checkOutput("bad_pulses", 32'(upd_pulses), 32'h0);
        dig[2] = BAD2;
        applyStimulus(3);
        err_clr = 1'b1;
        applyStimulus(1);
        err_clr = 1'b0;
        checkOutput("clr_vs_set", 32'(err_sticky), 32'h4);
        err_clr = 1'b1;
        applyStimulus(1);
        err_clr = 1'b0;
        checkOutput("clr_only", 32'(err_sticky), 32'h0);

        // Glitch on digit0 then back to "2": recommits the same value, no pulse.
        upd_pulses = 0;
        dig[0] = G8;
        applyStimulus(1);
        dig[0] = G2;
        applyStimulus(6);
        checkOutput("same_pulses", 32'(upd_pulses), 32'h0);
        checkOutput("same_value", 32'(value), 32'h00F2);
        dig[0] = BLANK;
        applyStimulus(4);
        checkOutput("blank_value", 32'(value), 32'h00F0);
        checkOutput("blank_valid", 32'(digit_valid), 32'h2);
        checkOutput("blank_update", 32'(update), 32'h1);

        // All digits to "8" at once: a single update pulse.
        upd_pulses = 0;
        for (int i = 0; i < 4; i++) dig[i] = G8;
        applyStimulus(3);
        checkOutput("all8_early", 32'(value), 32'h00F0);
        applyStimulus(1);
        checkOutput("all8_value", 32'(value), 32'h8888);
        checkOutput("all8_valid", 32'(digit_valid), 32'hF);
        applyStimulus(2);
        checkOutput("all8_pulses", 32'(upd_pulses), 32'h1);

        // Reset in the middle of a count, pattern held across deassertion.
        dig[0] = G2;
        applyStimulus(2);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("midrst_value", 32'(value), 32'h0);
        checkOutput("midrst_valid", 32'(digit_valid), 32'h0);
        checkOutput("midrst_update", 32'(update), 32'h0);
        checkOutput("midrst_errcnt", 32'(err_count), 32'h0);
        reset = 1'b0;
        applyStimulus(3);
        checkOutput("postrst_early", 32'(digit_valid), 32'h0);
        applyStimulus(1);
        checkOutput("postrst_value", 32'(value), 32'h8882);
        checkOutput("postrst_valid", 32'(digit_valid), 32'hF);

        // 300 error commits: 75 episodes on all four digits.
        for (int i = 0; i < 75; i++) begin
            for (int d = 0; d < 4; d++) dig[d] = (i % 2 == 0) ? BAD1 : BAD2;
            applyStimulus(4);
`ifdef SEG7_HEX_DECODER_ERR_CNT_EN
            if (i == 9) checkOutput("errcnt_40", 32'(err_count), 32'd40);
`endif
        end
        checkOutput("errs_sticky", 32'(err_sticky), 32'hF);
        checkOutput("errs_valid", 32'(digit_valid), 32'h0);
        checkOutput("errs_value", 32'(value), 32'h8882);
`ifdef SEG7_HEX_DECODER_ERR_CNT_EN
        checkOutput("errcnt_sat", 32'(err_count), 32'd255);
`else
        checkOutput("errcnt_tied", 32'(err_count), 32'd0);
`endif
        err_clr = 1'b1;
        applyStimulus(1);
        err_clr = 1'b0;
        checkOutput("final_clr_err", 32'(err_sticky), 32'h0);
        checkOutput("final_clr_cnt", 32'(err_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
